// File: rtl/calc_pkg.sv
// calc_pkg: key codes, ALU op and FSM state encodings for the keypad calculator
package calc_pkg;
  localparam logic [3:0] KEY_ADD = 4'd10, KEY_SUB = 4'd11, KEY_MUL = 4'd12, KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14, KEY_EQ = 4'd15;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} alu_op_t;
  typedef enum logic [2:0] {S_ENTER_A, S_ENTER_B, S_WAIT, S_SHOW, S_ERR} state_t;
  // operator keys 10..13 land on 0..3 by adding 2 modulo 4
  function automatic alu_op_t key_to_op(input logic [3:0] k);
    return alu_op_t'(k[1:0] + 2'd2);
  endfunction
endpackage

// File: rtl/calc_if.sv
// calc_if: start/done handshake between the sequencer (master) and the ALU (slave)
//   alu_start, alu_op, alu_a, alu_b   master -> slave; op/a/b held from start until done
//   alu_done, alu_err, alu_result     slave -> master; err/result qualified by done
interface calc_if
  import calc_pkg::*;
#(parameter int DATA_W = 32);
  logic alu_start, alu_done, alu_err;
  alu_op_t alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  modport master(output alu_start, alu_op, alu_a, alu_b, input alu_done, alu_err, alu_result);
  modport slave(input alu_start, alu_op, alu_a, alu_b, output alu_done, alu_err, alu_result);
endinterface

// File: rtl/calc_digit_acc.sv
// calc_digit_acc: decimal accumulator for the operand currently being typed
//   clr    zero value and digit count (highest priority)
//   load   value <= val, count <= 1
//   dig    value <= value*10 + val while fewer than DIGITS digits entered
//   value, count, full (count reached DIGITS)
module calc_digit_acc #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 2,
  localparam int CW = $clog2(DIGITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              dig,
  input  logic [3:0]        val,
  output logic [DATA_W-1:0] value,
  output logic [CW-1:0]     count,
  output logic              full
);
  assign full = count == CW'(DIGITS);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      value <= '0;
      count <= '0;
    end else if (clr) begin
      value <= '0;
      count <= '0;
    end else if (load) begin
      value <= DATA_W'(val);
      count <= CW'(1);
    end else if (dig && !full) begin
      value <= value * DATA_W'(10) + DATA_W'(val);
      count <= count + CW'(1);
    end
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad calculator controller building operands and sequencing the ALU
//   clk, rst_n            clock, asynchronous active-low reset
//   key_valid, key_code   one-cycle key strobe; 0-9 digit, 10-13 op, 14 CLEAR, 15 EQUALS
//   alu                   calc_if.master start/done handshake to the ALU
//   result, result_valid  last good result, high in SHOW
//   led1, led2, busy, err high in ENTER_A, ENTER_B, WAIT, ERR
//   CALC_TIMEOUT_EN       when defined, WAIT gives up after TIMEOUT_CYC cycles without done
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DIGITS      = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  calc_if.master            alu,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              led1,
  output logic              led2,
  output logic              busy,
  output logic              err
);
  localparam int CW = $clog2(DIGITS + 1);
  state_t state, state_nxt;
  alu_op_t op;
  logic [DATA_W-1:0] a_reg, acc_val;
  logic [CW-1:0] acc_cnt;
  logic acc_full, acc_clr, acc_load, acc_dig;
  logic a_from_acc, a_from_res, a_clr, op_ld, go, res_ld, abort_set;
  logic start, abort_pend, abort, tmo;
  logic is_dig, is_op, is_clr, is_eq;
  assign is_dig = key_valid && key_code < 4'd10;
  assign is_op  = key_valid && key_code >= KEY_ADD && key_code <= KEY_DIV;
  assign is_clr = key_valid && key_code == KEY_CLR;
  assign is_eq  = key_valid && key_code == KEY_EQ;
  // a CLEAR arriving together with alu_done still counts as an abort
  assign abort  = abort_pend || is_clr;
  calc_digit_acc #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_acc (
    .clk(clk), .rst_n(rst_n), .clr(acc_clr), .load(acc_load), .dig(acc_dig),
    .val(key_code), .value(acc_val), .count(acc_cnt), .full(acc_full)
  );
`ifdef CALC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= '0;
    else tcnt <= state == S_WAIT ? tcnt + TW'(1) : '0;
  assign tmo = state == S_WAIT && tcnt == TW'(TIMEOUT_CYC - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    acc_clr = 1'b0;
    acc_load = 1'b0;
    acc_dig = 1'b0;
    a_from_acc = 1'b0;
    a_from_res = 1'b0;
    a_clr = 1'b0;
    op_ld = 1'b0;
    go = 1'b0;
    res_ld = 1'b0;
    abort_set = 1'b0;
    case (state)
      S_ENTER_A: begin
        acc_dig = is_dig && !acc_full;
        if (is_op) begin
          a_from_acc = 1'b1;
          op_ld = 1'b1;
          acc_clr = 1'b1;
          state_nxt = S_ENTER_B;
        end
      end
      S_ENTER_B: begin
        acc_dig = is_dig && !acc_full;
        op_ld = is_op && acc_cnt == '0;
        if (is_eq) begin
          go = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT:
        if (alu.alu_done || tmo) begin
          state_nxt = abort ? S_ENTER_A : (alu.alu_done && !alu.alu_err) ? S_SHOW : S_ERR;
          res_ld = alu.alu_done && !alu.alu_err && !abort;
          acc_clr = abort;
          a_clr = abort;
        end else abort_set = is_clr;
      S_SHOW: begin
        acc_load = is_dig;
        if (is_dig) state_nxt = S_ENTER_A;
        if (is_op) begin
          a_from_res = 1'b1;
          op_ld = 1'b1;
          acc_clr = 1'b1;
          state_nxt = S_ENTER_B;
        end
      end
      default: ;
    endcase
    if (is_clr && state != S_WAIT) begin
      acc_clr = 1'b1;
      a_clr = 1'b1;
      state_nxt = S_ENTER_A;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_ENTER_A;
      op <= OP_ADD;
      a_reg <= '0;
      result <= '0;
      start <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      start <= go;
      abort_pend <= !go && (abort_pend || abort_set);
      if (a_clr) a_reg <= '0;
      else if (a_from_acc) a_reg <= acc_val;
      else if (a_from_res) a_reg <= result;
      if (op_ld) op <= key_to_op(key_code);
      if (res_ld) result <= alu.alu_result;
    end
  assign alu.alu_start = start;
  assign alu.alu_op = op;
  assign alu.alu_a = a_reg;
  assign alu.alu_b = acc_val;
  assign result_valid = state == S_SHOW;
  assign led1 = state == S_ENTER_A;
  assign led2 = state == S_ENTER_B;
  assign busy = state == S_WAIT;
  assign err = state == S_ERR;
endmodule
